// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types for the load/store memory access unit
package mem_access_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    localparam int CNT_W = 3;

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - load extension and sub-word store merge
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  access_size_e size,
    input  logic         zero_ext,
    input  logic [31:0]  rdata,
    input  logic [31:0]  wdata,
    output logic [31:0]  load_data,
    output logic [31:0]  merged_data
);

    always_comb begin
        load_data   = rdata;
        merged_data = wdata;
        case (size)
            BYTE: begin
                load_data   = {{24{~zero_ext & rdata[7]}}, rdata[7:0]};
                merged_data = {rdata[31:8], wdata[7:0]};
            end
            HALF: begin
                load_data   = {{16{~zero_ext & rdata[15]}}, rdata[15:0]};
                merged_data = {rdata[31:16], wdata[15:0]};
            end
            default: begin
                load_data   = rdata;
                merged_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit with read-modify-write for sub-word stores
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_raddress,
    output logic [31:0] mem_waddress,
    output logic [31:0] mem_datain,
    output logic        mem_wr,
    input  logic [31:0] mem_dataout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    access_size_e       size_q;
    logic               uns_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [31:0]        load_data;
    logic [31:0]        merged_data;
    logic               accept;
    logic               read_done;

    assign accept    = req_valid & req_ready;
    assign read_done = (state_q == READ) && (cnt_q == LAST_CNT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only full-word stores skip the read; sub-word stores need the old word to merge into.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (req_we && req_size[1]) ? WRITE : READ;
            READ:    if (read_done) state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size[1] ? WORD : access_size_e'(req_size);
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q != READ && state_d == READ) begin
                cnt_q <= '0;
            end else if (state_q == READ) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (read_done) begin
                rdata_q <= mem_dataout;
            end
        end
    end

    mem_byte_lane u_byte_lane (
        .size        (size_q),
        .zero_ext    (uns_q),
        .rdata       (rdata_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    always_comb begin
        req_ready    = (state_q == IDLE) && !Reset;
        resp_valid   = (state_q == RESP) && !Reset;
        resp_rdata   = (state_q == RESP && !we_q) ? load_data : '0;
        mem_wr       = (state_q == WRITE) && !Reset;
        mem_raddress = addr_q;
        mem_waddress = addr_q;
        mem_datain   = merged_data;
    end

endmodule
